// File: rtl/mips_boot_pkg.sv
// Shared state encoding and framing constants for the UART boot loader.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned LEN_W          = 8 * HDR_BYTES;
  localparam int unsigned SHIFT_W        = 8 * (BYTES_PER_WORD - 1);

  // A word count is loadable when it is non-zero and fits the memory.
  function automatic logic len_in_range(input logic [LEN_W-1:0] n,
                                        input int unsigned addr_width);
    return (n != '0) && (32'(n) <= (32'd1 << addr_width));
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// Inter-byte watchdog: counts while run is high, expired flags the last allowed cycle.
module boot_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && !expired) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign expired = run && (count_q == 32'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed UART byte stream into instruction memory while holding the CPU in reset.
// Define UART_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rx_flag,
  input  logic [7:0]            rx_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  boot_state_e           state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;
  logic                  cpu_reset_n_d, busy_d, done_d, error_d;
  logic                  to_clear_c, to_expired_c;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  boot_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear_c),
    .run     (busy),
    .expired (to_expired_c)
  );

  // Next-state and next-output logic; a watchdog expiry always beats a byte on the same edge.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    byte_idx_d    = byte_idx_q;
    word_cnt_d    = word_cnt_q;
    shift_d       = shift_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    cpu_reset_n_d = cpu_reset_n;
    done_d        = done;
    error_d       = error;
    to_clear_c    = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d       = ST_LEN_HI;
          to_clear_c    = 1'b1;
          done_d        = 1'b0;
          error_d       = 1'b0;
          cpu_reset_n_d = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (to_expired_c) begin
          state_d = ST_ERROR;
        end else if (rx_flag) begin
          len_d      = {rx_data, 8'h00};
          to_clear_c = 1'b1;
          state_d    = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (to_expired_c) begin
          state_d = ST_ERROR;
        end else if (rx_flag) begin
          len_d      = {len_q[LEN_W-1:8], rx_data};
          to_clear_c = 1'b1;
          if (len_in_range(len_d, ADDR_WIDTH)) begin
            state_d    = ST_DATA;
            byte_idx_d = '0;
            word_cnt_d = '0;
            mem_addr_d = '0;
`ifdef UART_BOOT_CHECKSUM_EN
            csum_d     = '0;
`endif
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DATA: begin
        if (to_expired_c) begin
          state_d = ST_ERROR;
        end else if (rx_flag) begin
          to_clear_c = 1'b1;
`ifdef UART_BOOT_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = DATA_WIDTH'({rx_data, shift_q});
            mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
            word_cnt_d  = word_cnt_q + CNT_W'(1);
            byte_idx_d  = '0;
            if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) begin
`ifdef UART_BOOT_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_DONE;
`endif
            end
          end else begin
            shift_d    = {rx_data, shift_q[SHIFT_W-1:8]};
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end
        end
      end
`ifdef UART_BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (to_expired_c) begin
          state_d = ST_ERROR;
        end else if (rx_flag) begin
          to_clear_c = 1'b1;
          state_d    = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      done_d        = 1'b1;
      cpu_reset_n_d = 1'b1;
    end
    if (state_d == ST_ERROR) begin
      error_d       = 1'b1;
      cpu_reset_n_d = 1'b0;
    end
    busy_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
             (state_d == ST_DATA)   || (state_d == ST_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_reset_n <= cpu_reset_n_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
    end
  end

`ifdef UART_BOOT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed and randomized load sequences checked against a stream-level model of the loader.
module tb_uart_boot_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rx_flag;
  logic [7:0]    rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_reset_n;
  logic          busy;
  logic          done;
  logic          error;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   wr_count = 0;
  logic [DW-1:0] last_wdata = '0;

  uart_boot_loader #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rx_flag     (rx_flag),
    .rx_data     (rx_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Counts every write strobe, so stray or missing pulses show up in totals.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count   <= wr_count + 1;
      last_wdata <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chkw(tag, 64'(obs), 64'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    tick();
    rx_flag = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Header, N random words, then a trailer byte (correct XOR unless bad_csum).
  function automatic bq_t make_stream(input int unsigned n, input bit bad_csum);
    bq_t         s;
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] n16;
    n16 = 16'(n);
    x   = 8'h00;
    s.push_back(n16[15:8]);
    s.push_back(n16[7:0]);
    for (int unsigned i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s.push_back(b);
      x = x ^ b;
    end
    s.push_back(bad_csum ? ~x : x);
    return s;
  endfunction

  // Drives a full load and predicts writes and outcome from the stream alone.
  task automatic run_load(input bq_t s);
    int unsigned   n;
    int unsigned   idx;
    int unsigned   base_wr;
    bit            len_ok;
    bit            ok;
    logic [7:0]    x;
    logic [DW-1:0] exp_word;
    n       = 32'({s[0], s[1]});
    len_ok  = (n != 0) && (n <= (32'd1 << AW));
    base_wr = wr_count;
    pulse_start();
    chk1("start_busy", busy, 1'b1);
    chk1("start_done_clr", done, 1'b0);
    chk1("start_err_clr", error, 1'b0);
    chk1("start_cpu_held", cpu_reset_n, 1'b0);
    for (int unsigned k = 0; k < s.size(); k++) begin
      send_byte(s[k]);
      if (k == 1 && !len_ok) begin
        chk1("len_err", error, 1'b1);
        chk1("len_err_cpu", cpu_reset_n, 1'b0);
      end
      if (len_ok && k >= 2) begin
        idx = k - 2;
        if (idx < 4 * n && idx % 4 == 3) begin
          exp_word = {s[k], s[k-1], s[k-2], s[k-3]};
          chk1("we_latency", mem_we, 1'b1);
          chkw("wr_addr", 64'(mem_addr), 64'(idx / 4));
          chkw("wr_data", 64'(mem_wdata), 64'(exp_word));
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    ok = len_ok;
`ifdef UART_BOOT_CHECKSUM_EN
    if (len_ok) begin
      x = 8'h00;
      for (int unsigned i = 0; i < 4 * n; i++) x = x ^ s[2+i];
      ok = (s.size() > 2 + 4 * n) && (s[2+4*n] == x);
    end
`else
    x = 8'h00;
`endif
    chkw("write_total", 64'(wr_count - base_wr), 64'(len_ok ? n : 0));
    chk1("end_done", done, ok);
    chk1("end_error", error, !ok);
    chk1("end_cpu_rst_n", cpu_reset_n, ok);
    chk1("end_busy", busy, 1'b0);
  endtask

  initial begin
    int unsigned n_wait;
    bq_t         s;
    reset   = 1'b0;
    start   = 1'b0;
    rx_flag = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    reset = 1'b1;

    chk1("rst_we", mem_we, 1'b0);
    chkw("rst_addr", 64'(mem_addr), 64'd0);
    chkw("rst_wdata", 64'(mem_wdata), 64'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_cpu", cpu_reset_n, 1'b0);

    // Bytes in IDLE are ignored.
    send_byte(8'hAA);
    tick();
    chk1("idle_ignore_busy", busy, 1'b0);
    chkw("idle_ignore_wr", 64'(wr_count), 64'd0);

    // Single-word reference load.
    s = {8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_load(s);
    chkw("ref_word", 64'(last_wdata), 64'h12345678);

    // Out-of-range lengths.
    s = {8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(s);
    s = {8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(s);

    // Inter-byte timeout measured in edges after the accepting edge.
    pulse_start();
    send_byte(8'h00);
    n_wait = 0;
    while (error !== 1'b1 && n_wait < 200) begin
      tick();
      n_wait++;
    end
    chkw("timeout_cycles", 64'(n_wait), 64'd100);
    chk1("timeout_cpu", cpu_reset_n, 1'b0);
    chk1("timeout_busy", busy, 1'b0);

    // A byte arriving on the expiry edge is dropped.
    pulse_start();
    send_byte(8'h00);
    repeat (99) tick();
    send_byte(8'h01);
    chk1("expiry_wins", error, 1'b1);
    chk1("expiry_busy", busy, 1'b0);

    // Start during DATA is ignored; reset abandons the load.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    chk1("start_ignored_busy", busy, 1'b1);
    send_byte(8'h33);
    send_byte(8'h44);
    chk1("mid_we", mem_we, 1'b1);
    chkw("mid_addr", 64'(mem_addr), 64'd0);
    chkw("mid_data", 64'(mem_wdata), 64'h44332211);
    send_byte(8'h55);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_we", mem_we, 1'b0);
    chk1("midrst_cpu", cpu_reset_n, 1'b0);
    n_wait = wr_count;
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    repeat (3) tick();
    chkw("midrst_no_wr", 64'(wr_count - n_wait), 64'd0);
    chk1("midrst_done", done, 1'b0);
    run_load(make_stream(2, 1'b0));

    // Checksum trailer cases.
    s = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(s);
    s = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(s);

    // Randomized loads, then the largest memory-sized load.
    for (int t = 0; t < 5; t++) begin
      run_load(make_stream($urandom_range(1, 5), 1'($urandom_range(0, 1))));
    end
    run_load(make_stream(256, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: memory word width; fixed at 32 (4 bytes per word).
- ADDR_WIDTH, default 8: instruction-memory address width.
- TIMEOUT_CYCLES, default 32'd50000000: inter-byte timeout in clk cycles (1 s at 50 MHz).
REQ-002 Ports SHALL be:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request a new program load; level-sampled.
- rx_flag  in  1  one-cycle pulse; rx_data holds a valid byte.
- rx_data  in  8  received UART byte.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  assembled word.
- cpu_reset_n  out  1  low holds the MIPS core in reset.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully.
- error  out  1  last load aborted.

Function
REQ-003 Byte stream format SHALL be: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, least-significant byte first.
REQ-004 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE and ERROR.
REQ-005 Transitions on start=1:
- IDLE, DONE or ERROR go to LEN_HI.
- done and error clear, and cpu_reset_n drives 0, in that same edge.
- start is ignored while busy.
REQ-006 busy SHALL be 1 exactly in LEN_HI, LEN_LO, DATA and CHECK.
REQ-007 rx_flag SHALL be ignored in IDLE, DONE and ERROR.
REQ-008 After LEN_LO is accepted:
- N=0 or N>2^ADDR_WIDTH: go to ERROR on the next edge.
- Otherwise go to DATA with word address 0.
REQ-009 In DATA, the edge that samples the 4th byte of a word SHALL register mem_wdata and mem_addr, so that mem_we=1 for exactly the following cycle (latency 1 cycle from the 4th rx_flag).
REQ-010 mem_addr SHALL advance by 1 after each write and SHALL NOT wrap; the address of the Nth word is N-1.
REQ-011 After the Nth write the FSM SHALL go to CHECK when CHECKSUM_EN is defined, otherwise to DONE.
REQ-012 Entering DONE SHALL set done=1 and cpu_reset_n=1 on the same edge.
REQ-013 In ERROR: error=1, cpu_reset_n=0, and memory writes already performed are not undone.
REQ-014 Timeout counter:
- Clears on every accepted byte and on entry to LEN_HI.
- Counts every cycle while busy.
- Reaching TIMEOUT_CYCLES-1 forces ERROR on the next edge.
- An rx_flag on that same edge is dropped and ERROR wins.
REQ-015 mem_we SHALL never assert outside DATA and its following cycle.

Reset
REQ-016 With reset=0 at a rising clk edge:
- State goes to IDLE.
- mem_we, mem_addr, mem_wdata, busy, done, error and the timeout counter go to 0.
- cpu_reset_n goes to 0.
REQ-017 Reset mid-load SHALL abandon the load with no further mem_we; the CPU stays held until a later load reaches DONE.

Configuration
REQ-018 With UART_BOOT_CHECKSUM_EN defined:
- One trailing byte SHALL follow the payload, equal to the XOR of all 4N payload bytes (length bytes excluded).
- In CHECK, a match goes to DONE and a mismatch goes to ERROR.
- The timeout also applies in CHECK.
REQ-019 Without UART_BOOT_CHECKSUM_EN:
- CHECK and the XOR accumulator SHALL NOT be synthesized.
- DONE follows the last write directly.

Structure
REQ-020 Package mips_boot_pkg SHALL hold:
- The state enum.
- Header byte count (2).
- Bytes-per-word (4).
REQ-021 The timeout counter SHALL be a sub-module boot_timeout with inputs clk, reset, clear, run and output expired.

Verification
REQ-022 Normal load: reset, then start, then bytes 00 01 78 56 34 12.
- Expect one mem_we at addr 0, data 32'h12345678.
- Then done=1 and cpu_reset_n=1.
REQ-023 Length out of range (ADDR_WIDTH=8):
- Bytes 01 01 give N=257; expect error=1 one cycle after the 2nd byte, no mem_we, cpu_reset_n=0.
- Bytes 00 00 give the same response.
REQ-024 Timeout: TIMEOUT_CYCLES=100; start, send byte 00, then idle.
- Expect error=1 exactly 100 cycles after the byte.
REQ-025 Restart and reset:
- start asserted during DATA: ignored.
- reset=0 mid-DATA: IDLE, no further mem_we.
- A new start after that: a full 2-word load writes addresses 0 and 1.
REQ-026 Checksum (UART_BOOT_CHECKSUM_EN defined):
- Payload 00 01 01 02 03 04 with trailer 04 gives done.
- The same payload with trailer 05 gives error and cpu_reset_n=0.
